// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, widths and FSM encodings shared by the sequencer and its ALU.
package alu_sequencer_pkg;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_DATA_W = 32;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SHL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SHR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_MOVR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_MOVRW = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_PACK = 4'd9;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_R  = 3'd1;
    localparam logic [2:0] S_RD_RW = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    function automatic logic op_legal(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_PACK;
    endfunction
endpackage

// File: rtl/alu_sequencer_alu.sv
// alu_sequencer_alu: combinational 32-bit ALU; shifts by 32 or more yield zero.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   op,
    input  logic [ALU_DATA_W-1:0] in_r,
    input  logic [ALU_DATA_W-1:0] in_rw,
    output logic [ALU_DATA_W-1:0] out,
    output logic                  is_zero
);
    logic big_shift;
    assign big_shift = |in_r[ALU_DATA_W-1:5];
    always_comb begin
        out = '0;
        case (op)
            ALU_ADD:   out = in_rw + in_r;
            ALU_SUB:   out = in_rw - in_r;
            ALU_SHL:   out = big_shift ? '0 : in_rw << in_r[4:0];
            ALU_SHR:   out = big_shift ? '0 : in_rw >> in_r[4:0];
            ALU_MOVR:  out = in_r;
            ALU_MOVRW: out = in_rw;
            ALU_AND:   out = in_rw & in_r;
            ALU_OR:    out = in_rw | in_r;
            ALU_XOR:   out = in_rw ^ in_r;
            ALU_PACK:  out = (in_r << 8) | in_rw;
            default:   out = '0;
        endcase
    end
    assign is_zero = (out == '0);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches two operands over one register-file port, runs the ALU,
// and writes the result back to the read/write operand's address.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr_r,
    input  logic [ADDR_W-1:0] req_addr_rw,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_rd_en,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero
);
    logic [2:0]          state_q, state_d;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_r_q, addr_rw_q;
    logic [DATA_W-1:0]   opnd_r_q, result_q, alu_out;
    logic                zero_q, alu_zero, legal;

    alu_sequencer_alu u_alu (
        .op     (op_q),
        .in_r   (opnd_r_q),
        .in_rw  (rf_rdata),
        .out    (alu_out),
        .is_zero(alu_zero)
    );

    assign legal   = op_legal(op_q);
    assign state_d = state_q == S_IDLE ? (req_valid ? S_RD_R : S_IDLE) :
                     state_q == S_WB   ? S_IDLE : 3'(state_q + 3'd1);

    // Result and flag commit at the end of EXEC so they are visible alongside done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_r_q  <= '0;
            addr_rw_q <= '0;
            opnd_r_q  <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                op_q      <= req_op;
                addr_r_q  <= req_addr_r;
                addr_rw_q <= req_addr_rw;
            end
            if (state_q == S_RD_RW) opnd_r_q <= rf_rdata;
            if (state_q == S_EXEC && legal) begin
                result_q <= alu_out;
                zero_q   <= alu_zero;
            end
        end
    end

    assign req_ready = state_q == S_IDLE;
    assign rf_rd_en  = state_q == S_RD_R || state_q == S_RD_RW;
    assign rf_wr_en  = state_q == S_WB && legal;
    assign rf_addr   = state_q == S_RD_R ? addr_r_q :
                       (state_q == S_RD_RW || rf_wr_en) ? addr_rw_q : '0;
    assign rf_wdata  = rf_wr_en ? result_q : '0;
    assign done      = state_q == S_WB;
    assign err       = state_q == S_WB && !legal;
    assign result    = result_q;
    assign flag_zero = zero_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized instructions against a register-file
// environment and an arithmetic reference of each opcode.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [7:0]  req_addr_r = '0, req_addr_rw = '0;
    logic [7:0]  rf_addr;
    logic        rf_rd_en, rf_wr_en, done, err, flag_zero;
    logic [31:0] rf_rdata = '0, rf_wdata, result;

    logic [31:0] rf [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] exp_res = '0;
    logic        exp_zero = 1'b0;
    int          n_checks = 0, n_err = 0;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr_r(req_addr_r), .req_addr_rw(req_addr_rw),
        .rf_addr(rf_addr), .rf_rd_en(rf_rd_en), .rf_rdata(rf_rdata),
        .rf_wr_en(rf_wr_en), .rf_wdata(rf_wdata), .done(done), .err(err),
        .result(result), .flag_zero(flag_zero)
    );

    always #5 clk = ~clk;

    // Register file: one-cycle read latency, preload port for the bench.
    always @(posedge clk) begin
        if (rf_rd_en) rf_rdata <= rf[rf_addr];
        if (rf_wr_en) rf[rf_addr] <= rf_wdata;
        if (pl_en) rf[pl_addr] <= pl_data;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            n_checks++;
            assert (!(rf_rd_en && rf_wr_en)) else begin
                n_err++;
                $error("FAIL rd_wr_overlap: observed rd=%0b wr=%0b expected not both", rf_rd_en, rf_wr_en);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] r, input logic [31:0] rw);
        case (op)
            4'd0: return rw + r;
            4'd1: return rw - r;
            4'd2: return (r >= 32) ? 32'd0 : rw << r;
            4'd3: return (r >= 32) ? 32'd0 : rw >> r;
            4'd4: return r;
            4'd5: return rw;
            4'd6: return rw & r;
            4'd7: return rw | r;
            4'd8: return rw ^ r;
            4'd9: return (r << 8) | rw;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] ar, input logic [7:0] arw);
        logic [31:0] expv;
        logic        legal;
        int          k;
        expv  = ref_alu(op, rf[ar], rf[arw]);
        legal = op <= 4'd9;
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr_r = ar; req_addr_rw = arw;
        @(negedge clk);
        req_valid = 1'b0; req_op = 4'($urandom); req_addr_r = 8'($urandom); req_addr_rw = 8'($urandom);
        k = 1;
        while (done !== 1'b1 && k < 8) begin
            chk("busy_ready", req_ready, 0);
            chk("no_early_wr", rf_wr_en, 0);
            if (k == 1) begin chk("rd_r_en", rf_rd_en, 1); chk("rd_r_addr", rf_addr, ar); end
            if (k == 2) begin chk("rd_rw_en", rf_rd_en, 1); chk("rd_rw_addr", rf_addr, arw); end
            if (k == 3) chk("exec_no_rd", rf_rd_en, 0);
            @(negedge clk);
            k++;
        end
        chk("latency", k, 4);
        chk("done", done, 1);
        chk("err", err, !legal);
        chk("wr_en", rf_wr_en, legal);
        if (legal) begin
            chk("wr_addr", rf_addr, arw);
            chk("wr_data", rf_wdata, expv);
            exp_res = expv;
            exp_zero = (expv == 0);
        end
        chk("result", result, exp_res);
        chk("flag_zero", flag_zero, exp_zero);
    endtask

    initial begin
        logic [31:0] e1, e2;
        int k, nbusy;
        foreach (rf[i]) rf[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rd_en", rf_rd_en, 0);
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_result", result, 0);
        chk("rst_flag", flag_zero, 0);
        reset_n = 1'b1;

        preload(8'd3, 32'd2536); preload(8'd5, 32'd113);
        run_op(4'd0, 8'd3, 8'd5);
        @(negedge clk); chk("add_rf5", rf[5], 32'd2649);
        preload(8'd7, 32'd500);
        run_op(4'd1, 8'd7, 8'd7);
        chk("sub_zero_flag", flag_zero, 1);
        run_op(4'hF, 8'd7, 8'd3);
        chk("illegal_result", result, 0);
        preload(8'd1, 32'd213); preload(8'd2, 32'd123);
        run_op(4'd9, 8'd1, 8'd2);
        @(negedge clk); chk("pack_rf2", rf[2], 32'd54651);
        preload(8'd1, 32'd4); preload(8'd2, 32'd2536);
        run_op(4'd3, 8'd1, 8'd2);
        @(negedge clk); chk("shr_rf2", rf[2], 32'd158);

        preload(8'd1, 32'd1000); preload(8'd2, 32'd77);
        e1 = ref_alu(4'd0, rf[1], rf[2]);
        e2 = ref_alu(4'd0, rf[1], e1);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_addr_r = 8'd1; req_addr_rw = 8'd2;
        for (int i = 0; i < 2; i++) begin
            k = 0; nbusy = 0;
            do begin
                @(negedge clk);
                k++;
                if (!req_ready) nbusy++;
            end while (done !== 1'b1 && k < 8);
            chk("b2b_latency", k, 4);
            chk("b2b_wdata", rf_wdata, i == 0 ? e1 : e2);
            if (i == 1) req_valid = 1'b0;
            @(negedge clk);
            chk("b2b_ready_back", req_ready, 1);
            chk("b2b_busy_cycles", nbusy, 4);
        end
        exp_res = e2; exp_zero = (e2 == 0);

        preload(8'd9, 32'd77); preload(8'd10, 32'd5);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_addr_r = 8'd9; req_addr_rw = 8'd10;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_flag", flag_zero, 0);
        chk("abort_wr", rf_wr_en, 0);
        reset_n = 1'b1;
        exp_res = '0; exp_zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_wr", rf_wr_en, 0);
        end
        chk("abort_rf10", rf[10], 32'd5);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ar, arw;
            ar  = 8'($urandom_range(0, 15));
            arw = 8'($urandom_range(0, 15));
            preload(ar, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom);
            if ($urandom_range(0, 7) != 0) preload(arw, $urandom_range(0, 5) == 0 ? 32'd0 : $urandom);
            run_op(4'($urandom_range(0, 15)), ar, arw);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
